// File: rtl/hazard_ctrl.sv
// Load-use / memory-wait / branch-flush sequencer. Controls are combinational, valid in the same cycle as state and inputs.
// Stalls freeze the PC and IF/ID. Optional perf counters are enabled by the HAZARD_PERF_CNT_EN macro.
module hazard_ctrl #(
  parameter int LOAD_USE_LAT = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_vld,
  input  logic        id_rs2_vld,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rd_vld,
  input  logic        ex_is_load,
  input  logic        ex_br_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic [1:0]  state,
  output logic        mem_timeout_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_BUBBLE   = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;
  localparam logic [1:0] S_FLUSH    = 2'd3;
  localparam logic [1:0] BUB_INIT   = (LOAD_USE_LAT > 1) ? 2'(LOAD_USE_LAT - 2) : 2'd0;
  localparam logic [7:0] TMO        = 8'(MEM_TIMEOUT);

  logic [1:0] r_state, w_next;
  logic [1:0] r_bub_cnt, w_bub_nxt;
  logic [7:0] r_wait_cnt, w_wait_nxt;
  logic       r_flush_pend, w_pend_nxt;
  logic       r_err, w_err_nxt;
  logic       w_hz, w_mem_stall;

  assign w_hz = ex_is_load && ex_rd_vld && (ex_rd != 5'd0) &&
                ((id_rs1_vld && (id_rs1 == ex_rd)) || (id_rs2_vld && (id_rs2 == ex_rd)));
  assign w_mem_stall = mem_req && !mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_bub_cnt    <= 2'd0;
      r_wait_cnt   <= 8'd0;
      r_flush_pend <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_bub_cnt    <= w_bub_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_flush_pend <= w_pend_nxt;
      r_err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_bub_nxt  = r_bub_cnt;
    w_wait_nxt = r_wait_cnt;
    w_pend_nxt = r_flush_pend;
    w_err_nxt  = r_err;
    case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          w_next     = S_MEM_WAIT;
          w_wait_nxt = 8'd0;
        end else begin
          w_pend_nxt = 1'b0;
          if (ex_br_taken) begin
            w_next = S_FLUSH;
          end else if (w_hz && (LOAD_USE_LAT > 1)) begin
            w_next    = S_BUBBLE;
            w_bub_nxt = BUB_INIT;
          end
        end
      end
      S_BUBBLE: begin
        if (r_bub_cnt == 2'd0) w_next = S_RUN;
        else                   w_bub_nxt = r_bub_cnt - 2'd1;
      end
      S_MEM_WAIT: begin
        if (mem_ack) begin
          w_next = S_RUN;
        end else if (r_wait_cnt == TMO) begin
          w_err_nxt = 1'b1;
          w_next    = S_RUN;
        end else begin
          w_wait_nxt = r_wait_cnt + 8'd1;
        end
      end
      default: begin
        // A memory stall during FLUSH defers the IF/ID flush until the wait ends.
        if (w_mem_stall) begin
          w_next     = S_MEM_WAIT;
          w_wait_nxt = 8'd0;
          w_pend_nxt = 1'b1;
        end else begin
          w_next = S_RUN;
        end
      end
    endcase
  end

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_mem_stall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
          end else if (ex_br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else begin
            ifid_flush = r_flush_pend;
            if (w_hz) begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_flush = 1'b1;
            end
          end
        end
        S_BUBBLE: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        S_MEM_WAIT: begin
          if (!mem_ack) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
          end
        end
        default: begin
          if (w_mem_stall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
          end else begin
            ifid_flush = 1'b1;
          end
        end
      endcase
    end
  end

  assign state           = r_state;
  assign mem_timeout_err = r_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (!pc_en) r_stall_cnt <= r_stall_cnt + 32'd1;
      if ((w_next == S_FLUSH) && (r_state != S_FLUSH)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; per-cycle expectations are queued at drive time and checked on the falling edge.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] rs1; logic rs1_v; logic [4:0] rs2; logic rs2_v;
    logic [4:0] rd;  logic rd_v;  logic ld; logic br; logic req; logic ack;
  } in_t;

  typedef struct packed {
    logic pc; logic ifid; logic ifl; logic idex; logic idfl;
    logic [1:0] st; logic err; logic [31:0] sc; logic [31:0] fc;
  } exp_t;

  // Control vectors, bit order {pc_en, ifid_en, ifid_flush, idex_en, idex_flush}
  localparam logic [4:0] C_NORM = 5'b11010;
  localparam logic [4:0] C_LU   = 5'b00011;
  localparam logic [4:0] C_BR   = 5'b11111;
  localparam logic [4:0] C_FL   = 5'b11110;
  localparam logic [4:0] C_STOP = 5'b00000;
  localparam logic [4:0] C_RST  = 5'b00101;

  logic        clk, rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_vld, id_rs2_vld, ex_rd_vld, ex_is_load, ex_br_taken, mem_req, mem_ack;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, mem_timeout_err;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_vld(id_rs1_vld), .id_rs2_vld(id_rs2_vld),
    .ex_rd(ex_rd), .ex_rd_vld(ex_rd_vld), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .state(state), .mem_timeout_err(mem_timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_total = 0;
  int    n_pass  = 0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;
  in_t   idle = '0;

  always @(negedge clk) begin
    exp_t  e, o;
    string t;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      o = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, state, mem_timeout_err, stall_cnt, flush_cnt};
      n_total++;
      assert (o === e) n_pass++;
      else $error("FAIL %s: observed=%h expected=%h", t, o, e);
    end
  end

  task automatic drive(input in_t in);
    {id_rs1, id_rs1_vld, id_rs2, id_rs2_vld, ex_rd, ex_rd_vld, ex_is_load, ex_br_taken, mem_req, mem_ack} = in;
  endtask

  // Called just after a rising edge; the expectation is checked on the following falling edge.
  task automatic step(input in_t in, input logic [4:0] c, input logic [1:0] st, input logic err, input string tag);
    exp_t e;
    rst_n = 1'b1;
    drive(in);
    e = {c, st, err, (PERF ? m_stall : 32'd0), (PERF ? m_flush : 32'd0)};
    if (!c[4]) m_stall++;
    if (st == 2'd0 && c[2] && c[0]) m_flush++;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk); #1;
  endtask

  task automatic rst_step(input string tag);
    rst_n = 1'b0;
    m_stall = 0;
    m_flush = 0;
    sb_q.push_back({C_RST, 2'd0, 1'b0, 32'd0, 32'd0});
    tag_q.push_back(tag);
    @(posedge clk); #1;
  endtask

  initial begin
    in_t lu, req_w, req_a;
    rst_n = 1'b1;
    drive(idle);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_step("reset_state");
    step(idle, C_NORM, 2'd0, 1'b0, "run_idle");

    lu = in_t'{rs1: 5'd5, rs1_v: 1'b1, rd: 5'd5, rd_v: 1'b1, ld: 1'b1, default: '0};
    step(lu,   C_LU,   2'd0, 1'b0, "loaduse_rs1");
    step(idle, C_NORM, 2'd0, 1'b0, "loaduse_done");
    step(in_t'{rs2: 5'd9, rs2_v: 1'b1, rd: 5'd9, rd_v: 1'b1, ld: 1'b1, default: '0},
         C_LU, 2'd0, 1'b0, "loaduse_rs2");
    step(in_t'{rs1: 5'd0, rs1_v: 1'b1, rd: 5'd0, rd_v: 1'b1, ld: 1'b1, default: '0},
         C_NORM, 2'd0, 1'b0, "nohz_rd0");
    step(in_t'{rs2: 5'd7, rs2_v: 1'b0, rd: 5'd7, rd_v: 1'b1, ld: 1'b1, default: '0},
         C_NORM, 2'd0, 1'b0, "nohz_rs2_inval");
    step(in_t'{rs1: 5'd5, rs1_v: 1'b1, rd: 5'd5, rd_v: 1'b1, ld: 1'b0, default: '0},
         C_NORM, 2'd0, 1'b0, "nohz_not_load");

    step(in_t'{br: 1'b1, default: '0}, C_BR, 2'd0, 1'b0, "branch_c0");
    step(idle, C_FL,   2'd3, 1'b0, "branch_c1");
    step(idle, C_NORM, 2'd0, 1'b0, "branch_c2");

    req_w = in_t'{req: 1'b1, ack: 1'b0, default: '0};
    req_a = in_t'{req: 1'b1, ack: 1'b1, default: '0};
    step(req_w, C_STOP, 2'd0, 1'b0, "memwait_enter");
    for (int i = 0; i < 3; i++) step(req_w, C_STOP, 2'd2, 1'b0, "memwait_hold");
    step(req_a, C_NORM, 2'd2, 1'b0, "memwait_ack");
    step(idle,  C_NORM, 2'd0, 1'b0, "memwait_exit");

    step(in_t'{br: 1'b1, default: '0}, C_BR, 2'd0, 1'b0, "flushmem_br");
    step(req_w, C_STOP, 2'd3, 1'b0, "flushmem_flush");
    step(req_w, C_STOP, 2'd2, 1'b0, "flushmem_wait");
    step(req_a, C_NORM, 2'd2, 1'b0, "flushmem_ack");
    step(idle,  C_FL,   2'd0, 1'b0, "flushmem_pending");
    step(idle,  C_NORM, 2'd0, 1'b0, "flushmem_done");

    step(req_w, C_STOP, 2'd0, 1'b0, "tmo_enter");
    for (int i = 0; i < 256; i++) step(req_w, C_STOP, 2'd2, 1'b0, "tmo_wait");
    step(req_w, C_STOP, 2'd0, 1'b1, "tmo_exit");
    for (int i = 0; i < 3; i++) step(req_w, C_STOP, 2'd2, 1'b1, "tmo_sticky");

    rst_step("rst_mid_memwait");
    step(idle, C_NORM, 2'd0, 1'b0, "rst_release");
    step(idle, C_NORM, 2'd0, 1'b0, "rst_run");

    @(posedge clk); #1;
    n_total++;
    assert (sb_q.size() === 0) n_pass++;
    else $error("FAIL scoreboard_drain: observed=%0d expected=0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
